// File: rtl/fetch_queue.sv
// Decoupling queue between fetch and decode: a circular buffer of {pc, instr, exc} entries, emptied in one cycle by flush.
// Optional zero-latency empty-queue bypass is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_instr,
  input  logic          in_exc,
  output logic          in_ready,
  output logic          out_valid,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_instr,
  output logic          out_exc,
  input  logic          out_ready,
  output logic [AW:0]   count
);

  // Handshake: a transfer occurs on a side in any cycle where its valid and
  // ready are both high and flush is low; flush kills both sides that cycle.

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]   pc_q    [DEPTH];
  logic [31:0]   pc_d    [DEPTH];
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   instr_d [DEPTH];
  logic          exc_q   [DEPTH];
  logic          exc_d   [DEPTH];

  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          bypass;
  logic          byp_consume;
  logic [31:0]   wr_instr;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign wr_idx   = wr_ptr_q[AW-1:0];
  assign rd_idx   = rd_ptr_q[AW-1:0];
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
  // A faulting fetch carries no meaningful word, so a nop travels with it.
  assign wr_instr = in_exc ? 32'h0 : in_instr;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass      = empty & in_valid & ~flush;
  assign byp_consume = bypass & out_ready;
`else
  assign bypass      = 1'b0;
  assign byp_consume = 1'b0;
`endif

  // in_ready depends on registered state only, so a same-cycle pop never frees a slot for a push.
  assign in_ready  = ~full;
  assign push      = in_valid & ~full & ~flush & ~byp_consume;
  assign pop       = ~empty & out_ready & ~flush;
  assign out_valid = ~empty | bypass;
  assign out_pc    = bypass ? in_pc    : pc_q[rd_idx];
  assign out_instr = bypass ? wr_instr : instr_q[rd_idx];
  assign out_exc   = bypass ? in_exc   : exc_q[rd_idx];
  assign count     = wr_ptr_q - rd_ptr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    exc_d    = exc_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        pc_d[wr_idx]    = in_pc;
        instr_d[wr_idx] = wr_instr;
        exc_d[wr_idx]   = in_exc;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
        exc_q[i]   <= 1'b0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      exc_q    <= exc_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed cycle table, in-order stream, and randomized traffic against a queue-based model.
// Build with FETCH_QUEUE_BYPASS_EN defined to exercise the bypass variant.
module tb_fetch_queue;

  localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_exc;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_exc;
  logic        out_ready;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // entry packing: {pc, instr, exc}
  logic [64:0] exp_q[$];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_exc(in_exc),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_exc(out_exc),
    .out_ready(out_ready), .count(count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic fl, input logic iv, input logic [31:0] pc,
                       input logic [31:0] ins, input logic ex, input logic ordy);
    @(negedge clk);
    rst = r; flush = fl; in_valid = iv; in_pc = pc; in_instr = ins; in_exc = ex; out_ready = ordy;
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic ov, input logic ir, input logic [2:0] cnt,
                          input logic chkd, input logic [31:0] opc, input logic [31:0] oins,
                          input logic oex);
    chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, ov});
    chk({tag, ".in_ready"},  {31'b0, in_ready},  {31'b0, ir});
    chk({tag, ".count"},     {29'b0, count},     {29'b0, cnt});
    if (chkd) begin
      chk({tag, ".out_pc"},    out_pc,    opc);
      chk({tag, ".out_instr"}, out_instr, oins);
      chk({tag, ".out_exc"},   {31'b0, out_exc}, {31'b0, oex});
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        flush, iv;
    logic [31:0] pc, instr;
    logic        exc, ordy;
    logic        ov, ir;
    logic [2:0]  cnt;
    logic        chkd;
    logic [31:0] opc, oinstr;
    logic        oexc;
  } vec_t;

  function automatic vec_t mk(input logic fl, input logic iv, input logic [31:0] pc,
                              input logic [31:0] ins, input logic ex, input logic ordy,
                              input logic ov, input logic ir, input logic [2:0] cnt,
                              input logic chkd, input logic [31:0] opc,
                              input logic [31:0] oins, input logic oex);
    vec_t v;
    v.flush = fl; v.iv = iv; v.pc = pc; v.instr = ins; v.exc = ex; v.ordy = ordy;
    v.ov = ov; v.ir = ir; v.cnt = cnt; v.chkd = chkd; v.opc = opc; v.oinstr = oins; v.oexc = ex & 1'b0 | oex;
    return v;
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [64:0] pack(input logic [31:0] pc, input logic [31:0] ins, input logic ex);
    return {pc, (ex ? 32'h0 : ins), ex};
  endfunction

  task automatic model_step();
    bit take_byp;
    bit do_pop;
    bit do_push;
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      take_byp = BYP && exp_q.size() == 0 && in_valid && out_ready;
      do_pop   = exp_q.size() > 0 && out_ready;
      do_push  = in_valid && exp_q.size() < DEPTH && !take_byp;
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(pack(in_pc, in_instr, in_exc));
    end
  endtask

  task automatic model_check();
    logic        ov;
    logic [64:0] hd;
    ov = exp_q.size() > 0 || (BYP && in_valid && !flush);
    hd = (exp_q.size() > 0) ? exp_q[0] : pack(in_pc, in_instr, in_exc);
    chk_outs("rnd", ov, exp_q.size() < DEPTH, 3'(exp_q.size()), ov, hd[64:33], hd[32:1], hd[0]);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t tbl[18];
    logic [31:0] pc;
    logic        ex;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; in_exc = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);

`ifndef FETCH_QUEUE_BYPASS_EN
    //              fl iv pc            instr         ex ordy  ov ir cnt chkd opc           oinstr        oexc
    tbl[0]  = mk(0, 0, 32'h0,        32'h0,        0, 0,    0, 1, 0, 1, 32'h0,        32'h0,        0);
    tbl[1]  = mk(0, 1, 32'hBFC00000, 32'h240000A0, 0, 0,    0, 1, 0, 1, 32'h0,        32'h0,        0);
    tbl[2]  = mk(0, 1, 32'hBFC00004, 32'h240000A1, 0, 0,    1, 1, 1, 1, 32'hBFC00000, 32'h240000A0, 0);
    tbl[3]  = mk(0, 1, 32'hBFC00008, 32'h240000A2, 0, 0,    1, 1, 2, 1, 32'hBFC00000, 32'h240000A0, 0);
    tbl[4]  = mk(0, 1, 32'hBFC0000C, 32'h240000A3, 0, 0,    1, 1, 3, 1, 32'hBFC00000, 32'h240000A0, 0);
    tbl[5]  = mk(0, 1, 32'hBFC00010, 32'h240000A4, 0, 0,    1, 0, 4, 1, 32'hBFC00000, 32'h240000A0, 0);
    tbl[6]  = mk(0, 1, 32'hBFC00010, 32'h240000A4, 0, 0,    1, 0, 4, 1, 32'hBFC00000, 32'h240000A0, 0);
    tbl[7]  = mk(0, 1, 32'hBFC00010, 32'h240000A4, 0, 1,    1, 0, 4, 1, 32'hBFC00000, 32'h240000A0, 0);
    tbl[8]  = mk(0, 1, 32'hBFC00010, 32'h240000A4, 0, 0,    1, 1, 3, 1, 32'hBFC00004, 32'h240000A1, 0);
    tbl[9]  = mk(0, 0, 32'h0,        32'h0,        0, 0,    1, 0, 4, 1, 32'hBFC00004, 32'h240000A1, 0);
    tbl[10] = mk(0, 0, 32'h0,        32'h0,        0, 1,    1, 0, 4, 1, 32'hBFC00004, 32'h240000A1, 0);
    tbl[11] = mk(1, 1, 32'hBFC00380, 32'h240000B0, 0, 1,    1, 1, 3, 1, 32'hBFC00008, 32'h240000A2, 0);
    tbl[12] = mk(0, 1, 32'hBFC00380, 32'h240000B0, 0, 0,    0, 1, 0, 0, 32'h0,        32'h0,        0);
    tbl[13] = mk(0, 0, 32'h0,        32'h0,        0, 0,    1, 1, 1, 1, 32'hBFC00380, 32'h240000B0, 0);
    tbl[14] = mk(0, 1, 32'hBFC00002, 32'h24020001, 1, 1,    1, 1, 1, 1, 32'hBFC00380, 32'h240000B0, 0);
    tbl[15] = mk(0, 0, 32'h0,        32'h0,        0, 0,    1, 1, 1, 1, 32'hBFC00002, 32'h0,        1);
    tbl[16] = mk(0, 0, 32'h0,        32'h0,        0, 1,    1, 1, 1, 1, 32'hBFC00002, 32'h0,        1);
    tbl[17] = mk(0, 0, 32'h0,        32'h0,        0, 0,    0, 1, 0, 0, 32'h0,        32'h0,        0);
    foreach (tbl[i]) begin
      drive(0, tbl[i].flush, tbl[i].iv, tbl[i].pc, tbl[i].instr, tbl[i].exc, tbl[i].ordy);
      chk_outs($sformatf("tbl%0d", i), tbl[i].ov, tbl[i].ir, tbl[i].cnt, tbl[i].chkd,
               tbl[i].opc, tbl[i].oinstr, tbl[i].oexc);
    end
`else
    // bypass: empty queue, consumer ready -> same-cycle delivery, nothing stored
    drive(0, 0, 0, 32'h0, 32'h0, 0, 0);
    chk_outs("byp_reset", 0, 1, 0, 1, 32'h0, 32'h0, 0);
    drive(0, 0, 1, 32'h80000000, 32'h24000001, 0, 1);
    chk_outs("byp_take", 1, 1, 0, 1, 32'h80000000, 32'h24000001, 0);
    drive(0, 0, 0, 32'h0, 32'h0, 0, 0);
    chk_outs("byp_after", 0, 1, 0, 0, 32'h0, 32'h0, 0);
    drive(0, 0, 1, 32'h80000006, 32'h24000002, 1, 0);
    chk_outs("byp_stall", 1, 1, 0, 1, 32'h80000006, 32'h0, 1);
    drive(0, 0, 0, 32'h0, 32'h0, 0, 1);
    chk_outs("byp_stored", 1, 1, 1, 1, 32'h80000006, 32'h0, 1);
    drive(0, 1, 1, 32'h80000010, 32'h24000003, 0, 1);
    chk_outs("byp_flush", 0, 1, 0, 0, 32'h0, 32'h0, 0);
`endif

    // steady stream of 10 with decode always ready
    for (int i = 0; i <= 10; i++) begin
      drive(0, 0, (i < 10), 32'h80001000 + 32'(4 * i), 32'h25000000 + 32'(i), 0, 1);
      if (BYP)
        chk_outs($sformatf("stream%0d", i), (i < 10), 1, 0, (i < 10),
                 32'h80001000 + 32'(4 * i), 32'h25000000 + 32'(i), 0);
      else
        chk_outs($sformatf("stream%0d", i), (i > 0), 1, (i > 0) ? 3'd1 : 3'd0, (i > 0),
                 32'h80001000 + 32'(4 * (i - 1)), 32'h25000000 + 32'(i - 1), 0);
    end
    drive(0, 0, 0, 32'h0, 32'h0, 0, 0);
    chk_outs("stream_end", 0, 1, 0, 0, 32'h0, 32'h0, 0);

    // mid-operation reset: fill, then reset with traffic present
    drive(0, 0, 1, 32'h80002000, 32'h26000000, 0, 0);
    drive(0, 0, 1, 32'h80002004, 32'h26000001, 0, 0);
    drive(1, 0, 1, 32'h80002008, 32'h26000002, 0, 1);
    drive(0, 0, 0, 32'h0, 32'h0, 0, 0);
    chk_outs("mid_rst", 0, 1, 0, 1, 32'h0, 32'h0, 0);

    // randomized traffic against the queue model
    exp_q.delete();
    for (int i = 0; i < 400; i++) begin
      ex = ($urandom_range(0, 7) == 0);
      pc = {$urandom_range(0, 32'h3FFFFFFF), 2'b00} | (ex ? 32'(1 + $urandom_range(0, 2)) : 32'h0);
      drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 9) < 7), pc, $urandom, ex, ($urandom_range(0, 9) < 6));
      model_check();
      @(posedge clk);
      model_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling instruction queue between the fetch stage and the decode stage. It buffers up to DEPTH fetched {PC, instruction, exception-flag} entries, so that cache or uncached-SRAM stalls in fetch and decode-side stalls do not propagate one-for-one. Any control-flow redirect discards the whole queue in a single cycle.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- AW, $clog2(DEPTH), pointer index width (derived; do not override)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  redirect (branch/jump taken, exception, eret); discards all entries
- in_valid  in  1  fetch presents a completed instruction (fetch not stalled, new PC)
- in_pc  in  32  PC of the presented instruction
- in_instr  in  32  instruction word
- in_exc  in  1  instruction-fetch address error (in_pc[1:0] != 0)
- in_ready  out  1  queue can accept; fetch holds PC when low
- out_valid  out  1  head entry available to decode
- out_pc  out  32  head PC
- out_instr  out  32  head instruction
- out_exc  out  1  head exception flag
- out_ready  in  1  decode consumes head this cycle (decode not stalled)
- count  out  AW+1  current occupancy, 0..DEPTH

## Operation
- Circular buffer of DEPTH entries; each entry is {pc[31:0], instr[31:0], exc}.
- wr_ptr and rd_ptr are AW+1 bits, with the MSB as the wrap bit.
  - empty: pointers are equal.
  - full: MSBs differ and low AW bits are equal.
  - count = wr_ptr − rd_ptr, modulo 2^(AW+1).
- push = in_valid & in_ready & !flush. A push writes the entry at wr_ptr[AW-1:0] and increments wr_ptr.
- pop = out_valid & out_ready & !flush. A pop increments rd_ptr.
- in_ready = !full, computed from registered state only. When the queue is full, a pop in the same cycle does not enable a push that cycle.
- If in_exc=1, the stored instr is forced to 32'h0 (nop) and in_instr is ignored. in_pc and exc are stored unchanged.
- out_valid = !empty. out_pc, out_instr and out_exc are a combinational mux of the entry at rd_ptr.
- Priority: rst > flush > push/pop.
  - flush clears wr_ptr and rd_ptr to 0.
  - A push presented in a flush cycle is dropped; fetch re-presents from the redirected PC.
  - Entry storage is not cleared by flush.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Pointer wrap: the low AW bits wrap DEPTH-1 → 0 and the wrap bit toggles.

## Timing
- Reset: wr_ptr=rd_ptr=0, all storage=0, out_valid=0, in_ready=1, count=0, out_pc=0, out_instr=0, out_exc=0.
- Latency without bypass: an entry pushed at edge N shows out_valid=1 in cycle N+1. Minimum queue latency is 1 cycle.
- Throughput: 1 push and 1 pop per cycle sustained, with no bubbles when count is 1..DEPTH-1.
- out_* are stable while out_valid=1 and out_ready=0, as long as there is no flush.
- flush asserted in cycle N: out_valid=0 and count=0 from cycle N+1. The pop in cycle N is also suppressed, so decode must treat its own input as killed by the same flush.
- Reset asserted mid-operation returns to the reset state at the next edge, regardless of other inputs.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined: when empty & in_valid & !flush, out_valid=1 in the same cycle and out_* = in_* (instr forced 0 if in_exc).
  - If out_ready=1 that cycle, the entry is consumed without being written and the pointers are unchanged.
  - Otherwise it is written normally.
  - Zero-latency path; in_ready is unaffected.
- FETCH_QUEUE_BYPASS_EN undefined: no combinational in→out path; minimum latency is 1 cycle as specified above.

## Test plan
- Reset, then push 4 entries (pc 0xBFC00000/04/08/0C) with out_ready=0 → count=4, in_ready=0. A 5th in_valid is ignored and count stays 4.
- Full queue, out_ready=1 and in_valid=1 in the same cycle → pop 0xBFC00000, no push, count=3. Next cycle the push is accepted.
- Steady stream of 10 instructions with out_ready=1 → outputs come out in order, no drops. count stays 1 (no bypass) or 0 (bypass). Pointers wrap twice.
- count=3 and flush=1 with in_valid=1 (pc 0xBFC00380) → next cycle count=0 and out_valid=0. The following push of 0xBFC00380 appears at the head.
- Push in_pc=0xBFC00002, in_exc=1, in_instr=0x24020001 → head shows out_exc=1, out_instr=0, out_pc=0xBFC00002.
- With FETCH_QUEUE_BYPASS_EN, empty queue, in_valid=1 and out_ready=1 (pc 0x80000000) → out_valid=1 in the same cycle with out_pc=0x80000000, and count stays 0.
